// File: rtl/calc_key_sequencer_pkg.sv
// Shared types for the calculator key sequencer.
// Status enum, key constants and sequencer states.
package calc_pkg;

  typedef enum logic [1:0] {
    ERRO    = 2'd0,
    PRONTA  = 2'd1,
    OCUPADA = 2'd2
  } calc_status_e;

  localparam logic [3:0] ADD       = 4'hA;
  localparam logic [3:0] SUB       = 4'hB;
  localparam logic [3:0] MUL       = 4'hC;
  localparam logic [3:0] EQ        = 4'hE;
  localparam logic [3:0] BKSP      = 4'hF;
  localparam logic [3:0] IDLE_CODE = 4'hD;

  typedef enum logic [2:0] {
    RECOVER,
    IDLE,
    ISSUE,
    GAP,
    WAIT_RESULT,
    FAULT
  } seq_state_e;

endpackage

// File: rtl/calc_key_sequencer_if.sv
// Key requesters A/B, calculator command/status, fault control.
// master: key sources + calculator model; slave: the sequencer.
interface calc_key_sequencer_if;

  logic                   a_req;
  logic [3:0]             a_code;
  logic                   a_ack;
  logic                   b_req;
  logic [3:0]             b_code;
  logic                   b_ack;
  calc_pkg::calc_status_e calc_status;
  logic [3:0]             calc_cmd;
  logic                   calc_cmd_valid;
  logic                   calc_rst;
  logic                   clear;
  logic                   fault;
  logic [2:0]             fifo_count;

  modport master (
    output a_req, a_code, b_req, b_code,
    output calc_status, clear,
    input  a_ack, b_ack, calc_cmd,
    input  calc_cmd_valid, calc_rst,
    input  fault, fifo_count
  );

  modport slave (
    input  a_req, a_code, b_req, b_code,
    input  calc_status, clear,
    output a_ack, b_ack, calc_cmd,
    output calc_cmd_valid, calc_rst,
    output fault, fifo_count
  );

endinterface

// File: rtl/calc_key_fifo.sv
// Key buffer: push/pop/flush, head data, count, full/empty.
// DEPTH must be a power of two; pointers wrap naturally.
module calc_key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [3:0]             push_data,
  output logic [3:0]             data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign data    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/calc_key_sequencer.sv
// Arbitrates two key sources into a FIFO and paces keys to a calculator.
// Ports: clock, reset (async, low), bus (slave modport).
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int GAP_CYCLES = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset,
  calc_key_sequencer_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // GAP plus the IDLE decision cycle together give GAP_CYCLES idle
  // cycles, so back-to-back keys land GAP_CYCLES+1 cycles apart.
  localparam logic [7:0] GAP_LAST =
    (GAP_CYCLES >= 2) ? 8'(GAP_CYCLES - 2) : 8'd0;

  seq_state_e    state_q;
  seq_state_e    state_d;
  logic          rr_q;
  logic          rec_q;
  logic [7:0]    gap_q;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [3:0]    head;
  logic          open_st;
  logic          grant_a;
  logic          grant_b;
  logic          push;
  logic          pop;
  logic          flush;
  logic [3:0]    push_data;

  assign open_st = (state_q == IDLE) || (state_q == ISSUE) ||
                   (state_q == GAP)  || (state_q == WAIT_RESULT);

  // rr_q=0 favours A on contention; lone requesters always win.
  assign grant_a = open_st & ~full & bus.a_req &
                   (~bus.b_req | ~rr_q);
  assign grant_b = open_st & ~full & bus.b_req &
                   (~bus.a_req | rr_q);

  assign push      = grant_a | grant_b;
  assign push_data = grant_a ? bus.a_code : bus.b_code;
  assign pop       = (state_q == ISSUE);
  assign flush     = (state_d == FAULT);

  calc_key_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (push_data),
    .data      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RECOVER;
      rr_q    <= 1'b0;
      rec_q   <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      rec_q   <= (state_q == RECOVER) & ~rec_q;
      gap_q   <= (state_q == GAP) ? gap_q + 8'd1 : 8'd0;
      if (grant_a)      rr_q <= 1'b1;
      else if (grant_b) rr_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RECOVER: begin
        if (rec_q) state_d = IDLE;
      end
      IDLE: begin
        if (bus.calc_status == ERRO) state_d = FAULT;
        else if (!empty)             state_d = ISSUE;
      end
      ISSUE: begin
        if (bus.calc_status == ERRO) state_d = FAULT;
        else if (head == EQ)         state_d = WAIT_RESULT;
        else                         state_d = GAP;
      end
      GAP: begin
        if (bus.calc_status == ERRO) state_d = FAULT;
        else if (gap_q == GAP_LAST)  state_d = IDLE;
      end
      WAIT_RESULT: begin
        if (bus.calc_status == ERRO)        state_d = FAULT;
        else if (bus.calc_status == PRONTA) state_d = IDLE;
      end
      FAULT: begin
        if (bus.clear) state_d = RECOVER;
      end
      default: state_d = RECOVER;
    endcase
  end

  assign bus.a_ack          = grant_a;
  assign bus.b_ack          = grant_b;
  assign bus.calc_cmd_valid = (state_q == ISSUE);
  assign bus.calc_cmd       = (state_q == ISSUE) ? head : IDLE_CODE;
  assign bus.calc_rst       = (state_q == RECOVER);
  assign bus.fault          = (state_q == FAULT);
  assign bus.fifo_count     = 3'(count);

endmodule

// File: doc/calc_key_sequencer.md
CALC_KEY_SEQUENCER -- requirements
Module: calc_key_sequencer

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 10, meaning idle cycles after each non-equals key.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning key buffer entries (power of two).
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 a_req  in  1  requester A (local keypad) key valid.
REQ-006 a_code  in  4  requester A key code.
REQ-007 a_ack  out  1  key from A accepted this cycle.
REQ-008 b_req  in  1  requester B (remote/UART) key valid.
REQ-009 b_code  in  4  requester B key code.
REQ-010 b_ack  out  1  key from B accepted this cycle.
REQ-011 calc_status  in  2  calculator status (ERRO=0, PRONTA=1, OCUPADA=2).
REQ-012 calc_cmd  out  4  command to calculator; IDLE_CODE (4'hD) when not issuing.
REQ-013 calc_cmd_valid  out  1  high exactly in the cycle a key is issued.
REQ-014 calc_rst  out  1  active-high synchronous reset to calculator.
REQ-015 clear  in  1  operator fault clear.
REQ-016 fault  out  1  sequencer halted on calculator error.
REQ-017 fifo_count  out  3  current buffer occupancy (0..FIFO_DEPTH).

Function
REQ-018 Acceptance SHALL occur when req=1, registered fifo_count < FIFO_DEPTH, and state is IDLE, ISSUE, GAP or WAIT_RESULT; ack is combinational in that same cycle.
REQ-019 At most one key SHALL be accepted per cycle; on simultaneous a_req and b_req, a round-robin pointer picks the winner (A after reset), pointer flips to the other requester after each grant.
REQ-020 A single requester SHALL be granted every cycle it requests while space exists, regardless of pointer.
REQ-021 When full, no ack SHALL assert even if a pop occurs the same cycle; push and pop in one cycle at non-full count leave count unchanged.
REQ-022 FSM states: RECOVER, IDLE, ISSUE, GAP, WAIT_RESULT, FAULT.
REQ-023 IDLE: if fifo_count>0 go to ISSUE next cycle; else stay.
REQ-024 ISSUE (1 cycle): pop head, calc_cmd=head code, calc_cmd_valid=1; next GAP if code != 4'hE, else WAIT_RESULT.
REQ-025 GAP: 8-bit counter counts GAP_CYCLES cycles, then IDLE; back-to-back keys thus issue every GAP_CYCLES+1 cycles.
REQ-026 WAIT_RESULT: stay until calc_status==PRONTA for 1 cycle, then IDLE; no timeout.
REQ-027 In IDLE, GAP or WAIT_RESULT, calc_status==ERRO SHALL force FAULT next cycle; ISSUE completes first, then FAULT.
REQ-028 FAULT: fifo_count cleared to 0 on entry, fault=1, no acks, calc_cmd=IDLE_CODE; on clear=1 go to RECOVER.
REQ-029 RECOVER: calc_rst=1 for exactly 2 cycles, calc_status ignored, no issue; then IDLE with fault=0.
REQ-030 Key codes SHALL be passed unmodified; the block never validates or reorders them (FIFO order preserved across requesters).

Reset
REQ-031 On reset low: state=RECOVER with recover counter 0, FIFO empty, fifo_count=0, rr pointer=A, a_ack=b_ack=0, calc_cmd=IDLE_CODE, calc_cmd_valid=0, calc_rst=1, fault=0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered keys and counters immediately; after release, the 2-cycle calc_rst pulse repeats.

Structure
REQ-033 Package calc_pkg SHALL hold the status enum (ERRO/PRONTA/OCUPADA), key constants ADD=4'hA, SUB=4'hB, MUL=4'hC, EQ=4'hE, BKSP=4'hF, IDLE_CODE=4'hD, and the sequencer state enum.
REQ-034 The buffer SHALL be sub-module calc_key_fifo (push, pop, flush, data, count, full, empty); arbiter and FSM stay in the top.

Verification
REQ-035 Reset release, no requests -> calc_rst high 2 cycles, then IDLE, calc_cmd=4'hD, fault=0.
REQ-036 A sends 1,2,A,3,E (status PRONTA except OCUPADA after A) -> calc_cmd_valid pulses 11 cycles apart carrying 1,2,A,3,E; after E no issue until status=PRONTA.
REQ-037 a_req and b_req held together with codes 5 and 7 -> acks alternate A,B,A,B; fifo fills to 4, then both acks low until a pop.
REQ-038 calc_status=0 during GAP with 3 keys buffered -> fault=1 next cycle, fifo_count=0, acks suppressed; clear=1 -> calc_rst 2 cycles, fault=0.
REQ-039 reset pulsed low while fifo_count=3 in WAIT_RESULT -> all outputs at reset values asynchronously; no buffered key issued afterward.
REQ-040 Full fifo with pop in same cycle as a_req -> no ack that cycle; ack next cycle, count returns to 4.
